// File: rtl/reflet_timer_pkg.sv
// Shared definitions for the reflet bus timer: register indices and CTRL layout.
// Register offsets are in units of one bus word.
package reflet_timer_pkg;

   localparam int PSEL_WIDTH = 4;

   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_RELOAD = 2'd1,
      REG_COUNT  = 2'd2,
      REG_STATUS = 2'd3
   } reg_sel_e;

   localparam int CTRL_RUN     = 0;
   localparam int CTRL_AUTO    = 1;
   localparam int CTRL_IRQ_EN  = 2;
   localparam int CTRL_PSEL_LO = 4;

   typedef struct packed {
      logic [PSEL_WIDTH-1:0] psel;
      logic                  irq_en;
      logic                  auto_reload;
      logic                  run;
   } ctrl_t;

   // Bus image of CTRL; bit 3 is a hole and reads as zero.
   function automatic logic [7:0] ctrl_to_byte(input ctrl_t c);
      return {c.psel, 1'b0, c.irq_en, c.auto_reload, c.run};
   endfunction

   function automatic ctrl_t byte_to_ctrl(input logic [7:0] b);
      return ctrl_t'({b[CTRL_PSEL_LO +: PSEL_WIDTH], b[CTRL_IRQ_EN], b[CTRL_AUTO], b[CTRL_RUN]});
   endfunction

endpackage

// File: rtl/reflet_timer_prescaler.sv
// Free-running prescaler for the timer: counts while running and decodes
// a tick whenever its low psel bits are all ones.
module reflet_timer_prescaler
   import reflet_timer_pkg::*;
#(
   parameter int presc_width = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [PSEL_WIDTH-1:0] psel,
   output logic                  tick
);

   logic [presc_width-1:0] count;
   logic [presc_width-1:0] mask;

   // psel at or beyond the counter width saturates to a full-width mask.
   always_comb begin
      mask = '0;
      for (int i = 0; i < presc_width; i++) begin
         if (i < int'(psel)) mask[i] = 1'b1;
      end
   end

   assign tick = run & enable & ((count & mask) == mask);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (run & enable) begin
         count <= count + presc_width'(1);
      end
   end

endmodule

// File: rtl/reflet_timer.sv
// Memory-mapped down-counting timer with level interrupt for the reflet bus.
// Holds the register file, address decode, read mux and expiry handling.
module reflet_timer
   import reflet_timer_pkg::*;
#(
   parameter int          wordsize    = 16,
   parameter int unsigned base_addr   = 'hFF00,
   parameter int          presc_width = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [wordsize-1:0] addr,
   input  logic [wordsize-1:0] data_in,
   input  logic                write_en,
   output logic [wordsize-1:0] data_out,
   output logic                irq
);

   localparam int W = wordsize / 8;
   localparam logic [wordsize-1:0] base = wordsize'(base_addr);

   ctrl_t               ctrl;
   logic [wordsize-1:0] reload;
   logic [wordsize-1:0] count;
   logic                pending;

   logic [wordsize-1:0] offset;
   logic                sel;
   reg_sel_e            rsel;
   logic                wr_ctrl, wr_reload, wr_count, wr_status;
   logic                tick, expire;
   logic [wordsize-1:0] rd_data;

   assign offset = addr - base;

   // Only the four word-aligned slots of the window decode; anything else is ignored.
   always_comb begin
      sel  = 1'b0;
      rsel = REG_CTRL;
      if (addr >= base) begin
         if (offset == wordsize'(0)) begin
            sel  = 1'b1;
            rsel = REG_CTRL;
         end else if (offset == wordsize'(W)) begin
            sel  = 1'b1;
            rsel = REG_RELOAD;
         end else if (offset == wordsize'(2 * W)) begin
            sel  = 1'b1;
            rsel = REG_COUNT;
         end else if (offset == wordsize'(3 * W)) begin
            sel  = 1'b1;
            rsel = REG_STATUS;
         end
      end
   end

   assign wr_ctrl   = write_en & sel & (rsel == REG_CTRL);
   assign wr_reload = write_en & sel & (rsel == REG_RELOAD);
   assign wr_count  = write_en & sel & (rsel == REG_COUNT);
   assign wr_status = write_en & sel & (rsel == REG_STATUS);

   reflet_timer_prescaler #(
      .presc_width (presc_width)
   ) u_presc (
      .clk    (clk),
      .reset  (reset),
      .run    (ctrl.run),
      .enable (enable),
      .clear  (wr_ctrl),
      .psel   (ctrl.psel),
      .tick   (tick)
   );

   assign expire = tick & (count == '0);

   // A CTRL write replaces the whole register, overriding a one-shot run clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl <= '0;
      end else if (wr_ctrl) begin
         ctrl <= byte_to_ctrl(data_in[7:0]);
      end else if (expire & ~ctrl.auto_reload) begin
         ctrl.run <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reload <= '0;
      end else if (wr_reload) begin
         reload <= data_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (wr_count) begin
         count <= data_in;
      end else if (tick) begin
         if (count != '0) begin
            count <= count - wordsize'(1);
         end else if (ctrl.auto_reload) begin
            count <= reload;
         end
      end
   end

   // Expiry beats a simultaneous software clear so no event is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= 1'b0;
      end else if (expire) begin
         pending <= 1'b1;
      end else if (wr_status & data_in[0]) begin
         pending <= 1'b0;
      end
   end

   always_comb begin
      rd_data = '0;
      if (sel) begin
         case (rsel)
            REG_CTRL:   rd_data = {{(wordsize-8){1'b0}}, ctrl_to_byte(ctrl)};
            REG_RELOAD: rd_data = reload;
            REG_COUNT:  rd_data = count;
            REG_STATUS: rd_data = {{(wordsize-1){1'b0}}, pending};
            default:    rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out <= '0;
      end else begin
         data_out <= rd_data;
      end
   end

   assign irq = pending & ctrl.irq_en;

endmodule

// File: tb/tb_reflet_timer.sv
// Scoreboard bench for reflet_timer: a behavioural model predicts data_out/irq
// per cycle into a queue, and a monitor pops and compares after each clock edge.
module tb_reflet_timer;

   localparam int WS   = 16;
   localparam int BASE = 'hFF00;
   localparam int W    = WS / 8;
   localparam int PW   = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [WS-1:0] addr;
   logic [WS-1:0] data_in;
   logic          write_en;
   logic [WS-1:0] data_out;
   logic          irq;

   always #5 clk = ~clk;

   reflet_timer #(
      .wordsize    (WS),
      .base_addr   (BASE),
      .presc_width (PW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .addr     (addr),
      .data_in  (data_in),
      .write_en (write_en),
      .data_out (data_out),
      .irq      (irq)
   );

   typedef struct {
      int            cyc;
      logic [WS-1:0] dout;
      logic          irq;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc_n = 0;

   // Reference state, kept as plain numbers.
   bit m_run, m_auto, m_irqen, m_pend;
   int m_psel, m_reload, m_count, m_presc;

   initial forever begin
      @(posedge clk);
      cyc_n++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h, wanted %0h", nm, cyc_n, act, expv);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_auto = 0; m_irqen = 0; m_pend = 0;
      m_psel = 0; m_reload = 0; m_count = 0; m_presc = 0;
      q.delete();
   endtask

   // Register index 0..3, or -1 for anything outside the aligned window.
   function automatic int reg_index(input logic [WS-1:0] a);
      int off;
      off = int'(a) - BASE;
      if (off < 0 || off >= 4 * W || (off % W) != 0) return -1;
      return off / W;
   endfunction

   function automatic logic [WS-1:0] model_read(input int idx);
      case (idx)
         0:       return WS'(int'(m_run) + 2 * int'(m_auto) + 4 * int'(m_irqen) + 16 * m_psel);
         1:       return WS'(m_reload);
         2:       return WS'(m_count);
         3:       return WS'(m_pend);
         default: return '0;
      endcase
   endfunction

   // One bus cycle: drive inputs, advance the model, queue the expected outputs.
   task automatic cycle(input logic [WS-1:0] a, input logic [WS-1:0] d,
                        input logic we, input logic en);
      exp_t e;
      int   idx, pe, span;
      bit   tick, expire;
      addr = a; data_in = d; write_en = we; enable = en;
      idx    = reg_index(a);
      e.cyc  = cyc_n + 1;
      e.dout = model_read(idx);
      pe     = (m_psel > PW) ? PW : m_psel;
      span   = 1 << pe;
      tick   = m_run && en && ((m_presc % span) == span - 1);
      expire = tick && (m_count == 0);
      if (we && idx == 0) m_presc = 0;
      else if (m_run && en) m_presc = (m_presc + 1) % (1 << PW);
      if (we && idx == 2) m_count = int'(d);
      else if (tick) begin
         if (m_count != 0) m_count = m_count - 1;
         else if (m_auto) m_count = m_reload;
      end
      if (we && idx == 1) m_reload = int'(d);
      if (expire) m_pend = 1;
      else if (we && idx == 3 && d[0]) m_pend = 0;
      if (we && idx == 0) begin
         m_run   = d[0];
         m_auto  = d[1];
         m_irqen = d[2];
         m_psel  = int'(d[7:4]);
      end else if (expire && !m_auto) begin
         m_run = 0;
      end
      e.irq = m_pend && m_irqen;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [WS-1:0] a, input logic [WS-1:0] d);
      cycle(a, d, 1'b1, 1'b1);
   endtask

   task automatic rd(input logic [WS-1:0] a);
      cycle(a, '0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      #2;
      write_en = 1'b0;
      reset    = 1'b1;
      #1;
      chk("reset_data_out", data_out, 0);
      chk("reset_irq", irq, 0);
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         while (q.size() > 0 && q[0].cyc <= cyc_n) begin
            e = q.pop_front();
            chk("data_out", data_out, e.dout);
            chk("irq", irq, e.irq);
         end
      end
   end

   localparam logic [WS-1:0] A_CTRL   = WS'(BASE);
   localparam logic [WS-1:0] A_RELOAD = WS'(BASE + W);
   localparam logic [WS-1:0] A_COUNT  = WS'(BASE + 2 * W);
   localparam logic [WS-1:0] A_STATUS = WS'(BASE + 3 * W);
   localparam logic [WS-1:0] A_UNALGN = WS'(BASE + 1);
   localparam logic [WS-1:0] A_OUTWIN = WS'(BASE + 4 * W);

   task automatic random_phase(input int n);
      logic [WS-1:0] addrs [6];
      logic [WS-1:0] a, d;
      int            k;
      addrs[0] = A_CTRL;   addrs[1] = A_RELOAD; addrs[2] = A_COUNT;
      addrs[3] = A_STATUS; addrs[4] = A_UNALGN; addrs[5] = A_OUTWIN;
      for (int i = 0; i < n; i++) begin
         k = int'($urandom_range(0, 5));
         a = addrs[k];
         case (k)
            0:       d = WS'(($urandom_range(0, 3) << 4) | $urandom_range(0, 7));
            1, 2:    d = WS'($urandom_range(0, 6));
            3:       d = WS'($urandom_range(0, 1));
            default: d = WS'($urandom);
         endcase
         cycle(a, d, ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 85));
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; write_en = 1'b0; addr = '0; data_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      chk("por_data_out", data_out, 0);
      chk("por_irq", irq, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Reset values of all registers.
      rd(A_CTRL); rd(A_RELOAD); rd(A_COUNT); rd(A_STATUS);

      // Auto-reload, period of four ticks at psel 0.
      wr(A_RELOAD, 3); wr(A_COUNT, 3); wr(A_CTRL, 16'h0007);
      for (int i = 0; i < 12; i++) rd((i % 2) ? A_COUNT : A_STATUS);

      // One-shot expiry after three ticks.
      wr(A_CTRL, 0); wr(A_STATUS, 1); wr(A_COUNT, 2); wr(A_CTRL, 16'h0005);
      for (int i = 0; i < 6; i++) rd((i % 3 == 0) ? A_CTRL : (i % 3 == 1) ? A_COUNT : A_STATUS);

      // Prescaled ticks with enable dropped mid-count.
      wr(A_STATUS, 1); wr(A_CTRL, 0); wr(A_COUNT, 1); wr(A_CTRL, 16'h0025);
      for (int i = 0; i < 3; i++) rd(A_STATUS);
      for (int i = 0; i < 5; i++) cycle(A_COUNT, '0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) rd(A_STATUS);

      // Status clear colliding with expiry, then a real clear.
      wr(A_STATUS, 1); wr(A_CTRL, 0); wr(A_COUNT, 2); wr(A_CTRL, 16'h0005);
      rd(A_COUNT); rd(A_COUNT); wr(A_STATUS, 1);
      rd(A_STATUS); wr(A_STATUS, 1); rd(A_STATUS); rd(A_STATUS);

      // Unaligned and out-of-window accesses.
      wr(A_UNALGN, 16'hFFFF); wr(A_OUTWIN, 16'h1234);
      rd(A_UNALGN); rd(A_OUTWIN);
      rd(A_CTRL); rd(A_RELOAD); rd(A_COUNT); rd(A_STATUS);

      random_phase(400);

      // Reset while counting with irq raised.
      wr(A_RELOAD, 50); wr(A_COUNT, 1); wr(A_CTRL, 16'h0007);
      for (int i = 0; i < 4; i++) rd(A_STATUS);
      do_reset();
      rd(A_CTRL); rd(A_RELOAD); rd(A_COUNT); rd(A_STATUS); rd(A_STATUS);

      random_phase(200);

      repeat (3) @(posedge clk);
      #5;
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
